pe_fp_tiled: RTL

PE_FP_TILED -- requirements
Module: pe_fp_tiled

---
 rtl/pe_fp_tiled.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pe_fp_tiled.sv
// Tiled fixed-point conv + max-pool + batch-norm binarisation processing element.
// Define PE_FP_TILED_MAXVAL_EN to expose the registered pooled maximum on max_out.
module pe_fp_tiled #(
  parameter int D                    = 512,
  parameter int LANES                = 16,
  parameter int FH                   = 3,
  parameter int FW                   = 3,
  parameter int POOL_H               = 2,
  parameter int POOL_W               = 2,
  parameter int STRIDE_H             = 1,
  parameter int STRIDE_W             = 1,
  parameter int DATA_IN_FP_WIDTH     = 16,
  parameter int DATA_IN_FP_INT_WIDTH = 8,
  localparam int N_KERNEL     = POOL_H * POOL_W,
  localparam int WIN_H        = (POOL_H - 1) * STRIDE_H + FH,
  localparam int WIN_W        = (POOL_W - 1) * STRIDE_W + FW,
  localparam int NBEATS       = D / LANES,
  localparam int ACC_WIDTH    = 2 * DATA_IN_FP_WIDTH + $clog2(FH * FW * D),
  localparam int PINDEX_WIDTH = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1,
  localparam int DIN_BITS     = WIN_H * WIN_W * LANES * DATA_IN_FP_WIDTH,
  localparam int WT_BITS      = FH * FW * LANES * DATA_IN_FP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIN_BITS-1:0]         data_in,
  input  logic [WT_BITS-1:0]          weight_in,
  input  logic signed [ACC_WIDTH-1:0] norm_ref,
  input  logic                        s,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        data_out,
  output logic [PINDEX_WIDTH-1:0]     pindex
`ifdef PE_FP_TILED_MAXVAL_EN
  ,
  output logic [ACC_WIDTH-1:0]        max_out
`endif
);

  localparam int W      = DATA_IN_FP_WIDTH;
  localparam int PROD_W = 2 * W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if ((D % LANES) != 0 || DATA_IN_FP_INT_WIDTH > DATA_IN_FP_WIDTH) begin : g_param_check
    $error("pe_fp_tiled: invalid parameter combination");
  end

  typedef enum logic [1:0] {ST_ACC, ST_POOL, ST_OUT} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            beat_cnt;
  logic signed [ACC_WIDTH-1:0] acc      [N_KERNEL];
  logic signed [ACC_WIDTH-1:0] beat_sum [N_KERNEL];
  logic signed [ACC_WIDTH-1:0] best;
  logic [PINDEX_WIDTH-1:0]     best_idx;
  logic signed [ACC_WIDTH-1:0] max_r;
  logic signed [ACC_WIDTH-1:0] norm_r;
  logic                        s_r;

  assign in_ready = (state == ST_ACC);

  // Per-kernel dot product of the current beat; MSB-first element packing.
  always_comb begin
    int unsigned de, we;
    logic signed [W-1:0]      a, b;
    logic signed [PROD_W-1:0] prod;
    de = 0;
    we = 0;
    a = '0;
    b = '0;
    prod = '0;
    for (int unsigned k = 0; k < N_KERNEL; k++) beat_sum[k] = '0;
    for (int unsigned i = 0; i < POOL_H; i++)
      for (int unsigned j = 0; j < POOL_W; j++)
        for (int unsigned m = 0; m < FH; m++)
          for (int unsigned n = 0; n < FW; n++)
            for (int unsigned l = 0; l < LANES; l++) begin
              de = ((i * STRIDE_H + m) * WIN_W + j * STRIDE_W + n) * LANES + l;
              we = (m * FW + n) * LANES + l;
              a = data_in[DIN_BITS - 1 - de * W -: W];
              b = weight_in[WT_BITS - 1 - we * W -: W];
              prod = PROD_W'(a) * PROD_W'(b);
              beat_sum[i * POOL_W + j] = beat_sum[i * POOL_W + j] + ACC_WIDTH'(prod);
            end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best = acc[0];
    best_idx = '0;
    for (int unsigned k = 1; k < N_KERNEL; k++) begin
      if (acc[k] > best) begin
        best = acc[k];
        best_idx = PINDEX_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      beat_cnt  <= '0;
      for (int unsigned k = 0; k < N_KERNEL; k++) acc[k] <= '0;
      out_valid <= 1'b0;
      data_out  <= 1'b0;
      pindex    <= '0;
      max_r     <= '0;
      norm_r    <= '0;
      s_r       <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < N_KERNEL; k++) begin
              if (beat_cnt == '0) acc[k] <= beat_sum[k];
              else                acc[k] <= acc[k] + beat_sum[k];
            end
            if (beat_cnt == CNT_W'(NBEATS - 1)) begin
              beat_cnt <= '0;
              norm_r   <= norm_ref;
              s_r      <= s;
              state    <= ST_POOL;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_POOL: begin
          max_r  <= best;
          pindex <= best_idx;
          state  <= ST_OUT;
        end
        ST_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            data_out  <= (max_r >= norm_r) ^ s_r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

`ifdef PE_FP_TILED_MAXVAL_EN
  assign max_out = max_r;
`endif

endmodule
